// File: rtl/vdcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdcm_pkg
// Description : Shared VDC-M decoder definitions: MPP sequencer state
//               encoding and substream / residual-group geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package vdcm_pkg;

   // Number of substream muxes feeding the MPP datapath
   localparam int NUM_SSM  = 4;
   // Quantized residuals per substream group
   localparam int QRES_GRP = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_FIRE    = 3'd2,
      ST_WAIT    = 3'd3,
      ST_OUT     = 3'd4
   } dec_mpp_st_e;

endpackage : vdcm_pkg
`default_nettype wire

// File: rtl/dec_mpp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dec_mpp_ctrl
// Description : Sequencer for the MPP decode datapath. Accepts mode tokens,
//               collects one qres group from each substream, fires the
//               fixed-latency reconstruction datapath and presents the
//               reconstructed block downstream. Owns the slice-relative
//               block counter.
// Ports       : clk, rstn (sync, active-low)
//               mode_vld/mode_rdy/mode_mpp/mode_fls : mode token input
//               ssm_vld/ssm_rdy                     : per-substream groups
//               slice_start, cfg_blks_per_slice     : slice control
//               dp_blk_vld/dp_isFls/dp_blkcounter   : datapath control
//               rec_vld/rec_rdy                     : reconstructed block
//               busy                                : not idle
// Revision    : 1.0 - initial release
// ============================================================================
module dec_mpp_ctrl
   import vdcm_pkg::*;
#(
   parameter int REC_LAT = 2,   // datapath latency, 1..15
   parameter int BLK_W   = 16
)(
   input  logic               clk,
   input  logic               rstn,
   input  logic               mode_vld,
   output logic               mode_rdy,
   input  logic               mode_mpp,
   input  logic               mode_fls,
   input  logic [NUM_SSM-1:0] ssm_vld,
   output logic [NUM_SSM-1:0] ssm_rdy,
   input  logic               slice_start,
   input  logic [BLK_W-1:0]   cfg_blks_per_slice,
   output logic               dp_blk_vld,
   output logic               dp_isFls,
   output logic [BLK_W-1:0]   dp_blkcounter,
   output logic               rec_vld,
   input  logic               rec_rdy,
   output logic               busy
);

   localparam logic [3:0]         c_WAIT_INIT = 4'(REC_LAT - 1);
   localparam logic [NUM_SSM-1:0] c_GOT_ALL   = {NUM_SSM{1'b1}};

   dec_mpp_st_e        r_state;
   logic [NUM_SSM-1:0] r_got;
   logic               r_fls;
   logic               r_pend;
   logic [BLK_W-1:0]   r_blk;
   logic [3:0]         r_wcnt;

   logic [NUM_SSM-1:0] w_ssm_hs;
   logic [NUM_SSM-1:0] w_got_nxt;
   logic [BLK_W-1:0]   w_cfg_m1;
   logic [BLK_W-1:0]   w_blk_inc;

   // Outputs are pure decodes of registered state: no input-to-output paths.
   assign mode_rdy      = (r_state == ST_IDLE);
   assign ssm_rdy       = (r_state == ST_COLLECT) ? ~r_got : '0;
   assign dp_blk_vld    = (r_state == ST_FIRE);
   assign rec_vld       = (r_state == ST_OUT);
   assign busy          = (r_state != ST_IDLE);
   assign dp_isFls      = r_fls;
   assign dp_blkcounter = r_blk;

   assign w_ssm_hs  = ssm_vld & ssm_rdy;
   assign w_got_nxt = r_got | w_ssm_hs;

   // cfg=0 gives all-ones here, so the counter wraps naturally at 2^BLK_W.
   assign w_cfg_m1  = cfg_blks_per_slice - BLK_W'(1);
   assign w_blk_inc = (r_blk == w_cfg_m1) ? '0 : r_blk + BLK_W'(1);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_got   <= '0;
         r_fls   <= 1'b0;
         r_pend  <= 1'b0;
         r_blk   <= '0;
         r_wcnt  <= '0;
      end else begin
         // A slice start seen mid-block is deferred until the block retires.
         if (slice_start && (r_state != ST_IDLE))
            r_pend <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (mode_vld) begin
                  if (mode_mpp) begin
                     r_fls   <= mode_fls;
                     r_got   <= '0;
                     r_state <= ST_COLLECT;
                     if (slice_start)
                        r_blk <= '0;
                  end else begin
                     // Skipped (non-MPP) block only moves the counter.
                     r_blk <= slice_start ? '0 : w_blk_inc;
                  end
               end else if (slice_start) begin
                  r_blk <= '0;
               end
            end

            ST_COLLECT: begin
               r_got <= w_got_nxt;
               if (w_got_nxt == c_GOT_ALL)
                  r_state <= ST_FIRE;
            end

            ST_FIRE: begin
               r_wcnt  <= c_WAIT_INIT;
               r_state <= (REC_LAT == 1) ? ST_OUT : ST_WAIT;
            end

            ST_WAIT: begin
               // FIRE already accounts for one latency cycle.
               r_wcnt <= r_wcnt - 4'd1;
               if (r_wcnt <= 4'd1)
                  r_state <= ST_OUT;
            end

            ST_OUT: begin
               if (rec_rdy) begin
                  r_state <= ST_IDLE;
                  r_pend  <= 1'b0;
                  r_blk   <= (r_pend || slice_start) ? '0 : w_blk_inc;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : dec_mpp_ctrl
`default_nettype wire

// File: tb/tb_dec_mpp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_mpp_ctrl
// Description : Directed self-checking bench for dec_mpp_ctrl (REC_LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_mpp_ctrl;

   localparam int BLK_W = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             mode_vld;
   logic             mode_rdy;
   logic             mode_mpp;
   logic             mode_fls;
   logic [3:0]       ssm_vld;
   logic [3:0]       ssm_rdy;
   logic             slice_start;
   logic [BLK_W-1:0] cfg_blks_per_slice;
   logic             dp_blk_vld;
   logic             dp_isFls;
   logic [BLK_W-1:0] dp_blkcounter;
   logic             rec_vld;
   logic             rec_rdy;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dec_mpp_ctrl #(.REC_LAT(2), .BLK_W(BLK_W)) dut (
      .clk                (clk),
      .rstn               (rstn),
      .mode_vld           (mode_vld),
      .mode_rdy           (mode_rdy),
      .mode_mpp           (mode_mpp),
      .mode_fls           (mode_fls),
      .ssm_vld            (ssm_vld),
      .ssm_rdy            (ssm_rdy),
      .slice_start        (slice_start),
      .cfg_blks_per_slice (cfg_blks_per_slice),
      .dp_blk_vld         (dp_blk_vld),
      .dp_isFls           (dp_isFls),
      .dp_blkcounter      (dp_blkcounter),
      .rec_vld            (rec_vld),
      .rec_rdy            (rec_rdy),
      .busy               (busy)
   );

   // Advance one clock; sample and drive 2 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rstn = 1'b0; mode_vld = 1'b0; mode_mpp = 1'b0; mode_fls = 1'b0;
      ssm_vld = 4'h0; slice_start = 1'b0; cfg_blks_per_slice = '0; rec_rdy = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      n_checks++;
      if ({mode_rdy, ssm_rdy, dp_blk_vld, rec_vld, busy, dp_isFls} !== 9'b1_0000_0000) begin
         n_errors++;
         $display("FAIL reset_ctrl: got rdy=%b ssm_rdy=%b fire=%b rec=%b busy=%b fls=%b, want 1 0000 0 0 0 0",
                  mode_rdy, ssm_rdy, dp_blk_vld, rec_vld, busy, dp_isFls);
      end
      n_checks++;
      if (dp_blkcounter !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_blk: got %0d want 0", dp_blkcounter);
      end
   endtask

   // Accept at T, all substreams at T+1, fire at T+2, rec_vld at T+4.
   task automatic test_min_block();
      mode_vld = 1'b1; mode_mpp = 1'b1; mode_fls = 1'b1;
      tick();
      mode_vld = 1'b0;
      n_checks++;
      if ({busy, mode_rdy, ssm_rdy, dp_blk_vld} !== 7'b1_0_1111_0) begin
         n_errors++;
         $display("FAIL min_collect: got busy=%b rdy=%b ssm_rdy=%b fire=%b, want 1 0 1111 0",
                  busy, mode_rdy, ssm_rdy, dp_blk_vld);
      end
      ssm_vld = 4'hF;
      tick();
      ssm_vld = 4'h0;
      n_checks++;
      if ({dp_blk_vld, ssm_rdy, rec_vld} !== 6'b1_0000_0) begin
         n_errors++;
         $display("FAIL min_fire: got fire=%b ssm_rdy=%b rec=%b, want 1 0000 0", dp_blk_vld, ssm_rdy, rec_vld);
      end
      tick();
      n_checks++;
      if ({dp_blk_vld, rec_vld} !== 2'b00) begin
         n_errors++;
         $display("FAIL min_wait: got fire=%b rec=%b, want 0 0", dp_blk_vld, rec_vld);
      end
      tick();
      n_checks++;
      if ({rec_vld, dp_isFls, dp_blkcounter} !== {1'b1, 1'b1, 16'd0}) begin
         n_errors++;
         $display("FAIL min_out: got rec=%b fls=%b blk=%0d, want 1 1 0", rec_vld, dp_isFls, dp_blkcounter);
      end
      rec_rdy = 1'b1;
      tick();
      rec_rdy = 1'b0;
      n_checks++;
      if ({rec_vld, mode_rdy, dp_blkcounter} !== {1'b0, 1'b1, 16'd1}) begin
         n_errors++;
         $display("FAIL min_done: got rec=%b rdy=%b blk=%0d, want 0 1 1", rec_vld, mode_rdy, dp_blkcounter);
      end
   endtask

   // Substreams arrive 3,0,2,1; each ready drops after its own handshake.
   task automatic test_out_of_order();
      logic [3:0] arr [4];
      logic [3:0] exp_rdy [4];
      arr = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
      exp_rdy = '{4'b0111, 4'b0110, 4'b0010, 4'b0000};
      mode_vld = 1'b1; mode_mpp = 1'b1; mode_fls = 1'b0;
      tick();
      mode_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         // keep previously-served substreams asserting to expose re-capture
         ssm_vld = arr[i] | (i > 0 ? arr[0] : 4'h0);
         tick();
         n_checks++;
         if (ssm_rdy !== exp_rdy[i]) begin
            n_errors++;
            $display("FAIL ooo_rdy[%0d]: got %b want %b", i, ssm_rdy, exp_rdy[i]);
         end
         n_checks++;
         if (dp_blk_vld !== (i == 3)) begin
            n_errors++;
            $display("FAIL ooo_fire[%0d]: got %b want %b", i, dp_blk_vld, (i == 3));
         end
      end
      ssm_vld = 4'h0;
      n_checks++;
      if (dp_isFls !== 1'b0) begin
         n_errors++;
         $display("FAIL ooo_fls: got %b want 0", dp_isFls);
      end
      tick(); tick();
      rec_rdy = 1'b1;
      tick();
      rec_rdy = 1'b0;
      n_checks++;
      if (dp_blkcounter !== 16'd2) begin
         n_errors++;
         $display("FAIL ooo_blk: got %0d want 2", dp_blkcounter);
      end
   endtask

   // cfg=3: idle slice_start clears, then five skipped blocks wrap 1,2,0,1,2.
   task automatic test_back_to_back();
      logic [15:0] exp_blk [5];
      exp_blk = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2};
      cfg_blks_per_slice = 16'd3;
      slice_start = 1'b1;
      tick();
      slice_start = 1'b0;
      n_checks++;
      if (dp_blkcounter !== 16'd0) begin
         n_errors++;
         $display("FAIL b2b_clear: got %0d want 0", dp_blkcounter);
      end
      mode_vld = 1'b1; mode_mpp = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({mode_rdy, busy, dp_blk_vld, dp_blkcounter} !== {3'b100, exp_blk[i]}) begin
            n_errors++;
            $display("FAIL b2b[%0d]: got rdy=%b busy=%b fire=%b blk=%0d want 1 0 0 %0d",
                     i, mode_rdy, busy, dp_blk_vld, dp_blkcounter, exp_blk[i]);
         end
      end
      mode_vld = 1'b0;
      cfg_blks_per_slice = 16'd0;
   endtask

   // Downstream stall: outputs hold, no token accepted.
   task automatic test_stall();
      mode_vld = 1'b1; mode_mpp = 1'b1; mode_fls = 1'b1;
      tick();
      mode_mpp = 1'b0;              // token stays offered during the stall
      ssm_vld = 4'hF;
      tick();
      ssm_vld = 4'h0;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({rec_vld, dp_isFls, mode_rdy, dp_blkcounter} !== {3'b110, 16'd2}) begin
            n_errors++;
            $display("FAIL stall[%0d]: got rec=%b fls=%b rdy=%b blk=%0d want 1 1 0 2",
                     i, rec_vld, dp_isFls, mode_rdy, dp_blkcounter);
         end
         tick();
      end
      mode_vld = 1'b0;
      rec_rdy = 1'b1;
      tick();
      rec_rdy = 1'b0;
      n_checks++;
      if ({rec_vld, dp_blkcounter} !== {1'b0, 16'd3}) begin
         n_errors++;
         $display("FAIL stall_done: got rec=%b blk=%0d want 0 3", rec_vld, dp_blkcounter);
      end
   endtask

   // slice_start during WAIT at counter 5 takes effect on return to IDLE.
   task automatic test_slice_pending();
      mode_vld = 1'b1; mode_mpp = 1'b0;
      tick(); tick();
      mode_vld = 1'b0;
      n_checks++;
      if (dp_blkcounter !== 16'd5) begin
         n_errors++;
         $display("FAIL pend_pre: got %0d want 5", dp_blkcounter);
      end
      mode_vld = 1'b1; mode_mpp = 1'b1; mode_fls = 1'b0;
      tick();
      mode_vld = 1'b0;
      ssm_vld = 4'hF;
      tick();
      ssm_vld = 4'h0;
      tick();                       // now in WAIT
      slice_start = 1'b1;
      tick();
      slice_start = 1'b0;
      n_checks++;
      if ({rec_vld, dp_blkcounter} !== {1'b1, 16'd5}) begin
         n_errors++;
         $display("FAIL pend_out: got rec=%b blk=%0d want 1 5", rec_vld, dp_blkcounter);
      end
      rec_rdy = 1'b1;
      tick();
      rec_rdy = 1'b0;
      n_checks++;
      if (dp_blkcounter !== 16'd0) begin
         n_errors++;
         $display("FAIL pend_idle: got %0d want 0", dp_blkcounter);
      end
      mode_vld = 1'b1; mode_mpp = 1'b1;
      tick();
      mode_vld = 1'b0;
      n_checks++;
      if ({busy, dp_blkcounter} !== {1'b1, 16'd0}) begin
         n_errors++;
         $display("FAIL pend_next: got busy=%b blk=%0d want 1 0", busy, dp_blkcounter);
      end
      ssm_vld = 4'hF;
      tick();
      ssm_vld = 4'h0;
      tick(); tick();
      rec_rdy = 1'b1;
      tick();
      rec_rdy = 1'b0;
      n_checks++;
      if (dp_blkcounter !== 16'd1) begin
         n_errors++;
         $display("FAIL pend_after: got %0d want 1", dp_blkcounter);
      end
   endtask

   // Reset while collecting with two groups captured aborts the block.
   task automatic test_reset_mid();
      mode_vld = 1'b1; mode_mpp = 1'b1;
      tick();
      mode_vld = 1'b0;
      ssm_vld = 4'b0101;
      tick();
      ssm_vld = 4'h0;
      n_checks++;
      if (ssm_rdy !== 4'b1010) begin
         n_errors++;
         $display("FAIL rmid_got: got ssm_rdy=%b want 1010", ssm_rdy);
      end
      rstn = 1'b0;
      tick();
      n_checks++;
      if ({mode_rdy, ssm_rdy, dp_blk_vld, busy, rec_vld, dp_blkcounter} !== {8'b1_0000_000, 16'd0}) begin
         n_errors++;
         $display("FAIL rmid_idle: got rdy=%b ssm_rdy=%b fire=%b busy=%b rec=%b blk=%0d want 1 0000 0 0 0 0",
                  mode_rdy, ssm_rdy, dp_blk_vld, busy, rec_vld, dp_blkcounter);
      end
      rstn = 1'b1;
      ssm_vld = 4'hF;
      tick();
      ssm_vld = 4'h0;
      n_checks++;
      if ({dp_blk_vld, busy, rec_vld} !== 3'b000) begin
         n_errors++;
         $display("FAIL rmid_after: got fire=%b busy=%b rec=%b want 0 0 0", dp_blk_vld, busy, rec_vld);
      end
   endtask

   initial begin
      test_reset();
      test_min_block();
      test_out_of_order();
      test_back_to_back();
      test_stall();
      test_slice_pending();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_dec_mpp_ctrl
`default_nettype wire

// File: doc/dec_mpp_ctrl.md
# dec_mpp_ctrl

Sequencer for the MPP (midpoint prediction) decode datapath of the VDC-M decoder. It takes per-block mode tokens from the mode decoder and collects one quantized-residual group from each of the four substream muxes. It then fires the MPP reconstruction datapath, which has a fixed latency, and hands the reconstructed block downstream with a valid/ready handshake. It owns the slice-relative block counter used by the datapath for its first-block and left-neighbour rules.

## Interface
- REC_LAT, 2: MPP datapath latency in cycles, from dp_blk_vld to reconstructed samples valid; legal range 1..15.
- BLK_W, 16: block counter width.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- mode_vld  in  1  mode token valid.
- mode_rdy  out  1  mode token accepted when mode_vld&mode_rdy.
- mode_mpp  in  1  block is MPP-coded.
- mode_fls  in  1  MPP fallback (MPPF) variant; ignored when mode_mpp=0.
- ssm_vld  in  4  substream i has a 16-entry qres group ready.
- ssm_rdy  out  4  substream i group consumed when ssm_vld[i]&ssm_rdy[i]; also the capture enable of the datapath input register i.
- slice_start  in  1  pulse: next block is block 0 of a new slice.
- cfg_blks_per_slice  in  BLK_W  blocks per slice; 0 means 2^BLK_W.
- dp_blk_vld  out  1  one-cycle fire strobe to the datapath.
- dp_isFls  out  1  MPPF flag, held stable from fire until rec handshake.
- dp_blkcounter  out  BLK_W  block index in slice, stable while not IDLE.
- rec_vld  out  1  reconstructed block available.
- rec_rdy  in  1  downstream accepts.
- busy  out  1  state≠IDLE.

## Operation
- States: IDLE, COLLECT, FIRE, WAIT, OUT.
- IDLE: mode_rdy=1. On accept with mode_mpp=1: latch mode_fls → COLLECT, clear got[3:0]. On accept with mode_mpp=0: blkcounter advances, stay IDLE, no other output.
- COLLECT: ssm_rdy[i]=!got[i]; substreams are consumed independently and in any order; got[i] sets on handshake. Leave for FIRE on the cycle in which (got | handshakes)==4'hF.
- FIRE: dp_blk_vld=1 for exactly one cycle, load wait counter=REC_LAT-1 → WAIT; when REC_LAT=1, go directly to OUT.
- WAIT: decrement; at 0 → OUT.
- OUT: rec_vld=1 until rec_rdy; on handshake, blkcounter advances → IDLE.
- Counter advance: blkcounter+1, wrapping to 0 when blkcounter==cfg_blks_per_slice-1 (natural wrap when cfg=0).
- slice_start: applied at the IDLE mode-accept cycle (the accepted block uses index 0) or, with no accept, clears the counter in IDLE. A slice_start outside IDLE sets pending, which is applied at the next return to IDLE. slice_start has priority over the advance in the same cycle.
- ssm_rdy=0 and mode_rdy=0 in every state other than those listed.

## Timing
- Reset: state=IDLE, all outputs 0 except mode_rdy=1; blkcounter=0, got=0, pending=0.
- Minimum MPP block: accept at T, all four substreams valid at T+1 → FIRE at T+2, rec_vld at T+2+REC_LAT, back in IDLE at T+3+REC_LAT when rec_rdy=1 → throughput 3+REC_LAT cycles per block.
- Non-MPP tokens: one per cycle.
- Reset mid-block aborts with no rec_vld. Already-captured substream data is discarded by the consumer.

## Structure
- Shared package vdcm_pkg: state enum dec_mpp_st_e, NUM_SSM=4, QRES_GRP=16.
- No sub-module; a single FSM plus counters.

## Test plan
- Reset, then MPP token with all ssm_vld=4'hF at T+1, REC_LAT=2 → dp_blk_vld at T+2, rec_vld at T+4, dp_blkcounter=0, counter 1 after handshake.
- Substreams arrive in order 3,0,2,1 one per cycle → each ssm_rdy[i] drops after its handshake; FIRE one cycle after the last arrival; no double capture.
- cfg_blks_per_slice=3, five non-MPP tokens back-to-back → counter 1,2,0,1,2; mode_rdy is never 0.
- rec_rdy held 0 for 10 cycles → rec_vld, dp_isFls and dp_blkcounter stay stable; mode_rdy=0 throughout.
- slice_start pulsed during WAIT at counter 5 → counter 0 on return to IDLE; the next block reports index 0.
- rstn low during COLLECT with got=4'b0101 → next cycle IDLE, mode_rdy=1, ssm_rdy=0, no dp_blk_vld.
